cache_tag_lookup: RTL and testbench
===================================

Name: cache_tag_lookup

Overview:
- Set-associative tag store with tree pseudo-LRU replacement.
- Sits directly downstream of the address parser and consumes its tag/index fields; byte_select bypasses this block.
- Per request: reports hit/miss and the selected way; on a miss, allocates a way and reports any evicted tag.
- Keeps hit and miss statistics for the trace-driven cache simulation.

Parameters:
- ADDR_W, 64, address width in bits
- LINE_BITS, 6, log2 of line size in bytes (byte_select width)
- CAP_BITS, 14, log2 of cache capacity in bytes
- WAY_BITS, 3, log2 of associativity (8 ways)
- Derived constants:
  - INDEX_W = CAP_BITS - WAY_BITS - LINE_BITS (5, so 32 sets)
  - TAG_W = ADDR_W - INDEX_W - LINE_BITS (53)
  - WAYS = 2**WAY_BITS

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  2  0=READ, 1=WRITE, 2=INVALIDATE, 3=CLEAR_ALL
- req_tag  in  TAG_W  tag field from the address parser
- req_index  in  INDEX_W  set index from the address parser
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_hit  out  1  tag matched a valid way
- rsp_way  out  WAY_BITS  hit way, allocated way, or 0 for CLEAR_ALL
- rsp_evict  out  1  a valid line was displaced by allocation
- rsp_evict_tag  out  TAG_W  tag of the displaced line
- hit_count  out  32  saturating count of READ/WRITE hits
- miss_count  out  32  saturating count of READ/WRITE misses

Behaviour:
- Storage per set: WAYS x {valid, tag} plus WAYS-1 PLRU tree bits.
- Reset (asynchronous, all outputs and state):
  - all valid bits 0, all PLRU bits 0, both counters 0
  - req_ready 1, rsp_valid 0, all other rsp_* outputs 0, FSM in IDLE
- FSM states and transitions:
  - IDLE: req_ready=1. When req_valid, the request is captured on that edge. Go to FLUSH if op is CLEAR_ALL, otherwise COMPARE.
  - COMPARE (1 cycle): compare req_tag against all ways of the captured set in parallel; hit = any valid match. On a miss, the victim is the lowest-numbered invalid way, or the PLRU victim if the set is full.
  - UPDATE (1 cycle): apply the per-op update rules below.
  - FLUSH: clear the valid bits and PLRU bits of one set per cycle, set 0 upward. Exactly 2**INDEX_W cycles, then go to RESP with rsp_hit=0, rsp_way=0, rsp_evict=0.
  - RESP: rsp_valid=1 and every rsp_* output held stable until rsp_ready. The response transfers on the edge where rsp_valid && rsp_ready; then go to IDLE.
- Update rules:
  - READ/WRITE hit: touch the PLRU toward the hit way; increment hit_count.
  - READ/WRITE miss: write the tag into the victim and set its valid bit; touch the PLRU toward the victim; rsp_evict=1 only if the victim was valid; increment miss_count.
  - INVALIDATE: on a hit, clear that way's valid bit. No PLRU change and no counter change. rsp_hit reports the match result.
- Latency: acceptance edge T -> rsp_valid high after edge T+3 (COMPARE, UPDATE, RESP). One request in flight at a time; req_ready=0 outside IDLE.
- PLRU tree:
  - bit 0 is the root; the children of node n are 2n+1 and 2n+2
  - bit value 0 means the victim lies in the lower half
  - a touch sets every node on the path to point away from the accessed way
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- WRITE behaves identically to READ here (write-allocate); dirty/MESI state is owned downstream.
- The response may stall indefinitely (rsp_ready low); no state changes during the stall.
- Reset asserted mid-operation (including mid-FLUSH) aborts immediately and gives full reset state; no partial response is emitted.

Decomposition:
- Package cache_pkg holds:
  - the op enum, the FSM state enum, the LINE_BITS/CAP_BITS/WAY_BITS defaults
  - the INDEX_W/TAG_W/WAYS derivations, shared with the address parser so the field widths agree
- Sub-module plru_tree: combinational victim select from the tree bits, plus next-tree computation for a touched way. Parameterised by WAY_BITS.

Test Plan:
- Reset: after rst_n release -> req_ready=1, rsp_valid=0, hit_count=miss_count=0.
- Cold miss: READ tag=0x1A, index=3 -> rsp_hit=0, rsp_way=0, rsp_evict=0, miss_count=1, with rsp_valid 3 cycles after acceptance. Repeat the READ -> rsp_hit=1, rsp_way=0, hit_count=1.
- Eviction: READ tags 0x10..0x17 into index 5 (ways 0..7 in order), then READ tag 0x18 index 5 -> rsp_hit=0, rsp_way=0, rsp_evict=1, rsp_evict_tag=0x10.
- Invalidate: INVALIDATE tag 0x11 index 5 -> rsp_hit=1, rsp_way=1, counters unchanged. A following READ 0x11 -> miss allocated to way 1 (lowest invalid way), rsp_evict=0.
- CLEAR_ALL and backpressure:
  - CLEAR_ALL -> rsp_valid exactly 32 FLUSH cycles + 1 after acceptance; every later READ misses.
  - Hold rsp_ready=0 for 10 cycles -> rsp_* stable throughout, req_ready=0.
- Reset mid-FLUSH: assert rst_n=0 while in FLUSH -> outputs return to reset values asynchronously; no response is emitted.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared geometry, op/state enums and helpers for the tag lookup
// Purpose: single source of the address field widths so the address parser and
// the tag store always agree on tag/index widths.
package cache_pkg;

    localparam int ADDR_W    = 64;
    localparam int LINE_BITS = 6;
    localparam int CAP_BITS  = 14;
    localparam int WAY_BITS  = 3;

    localparam int INDEX_W = CAP_BITS - WAY_BITS - LINE_BITS;
    localparam int TAG_W   = ADDR_W - INDEX_W - LINE_BITS;
    localparam int WAYS    = 2 ** WAY_BITS;

    typedef enum logic [1:0] {
        OP_READ       = 2'd0,
        OP_WRITE      = 2'd1,
        OP_INVALIDATE = 2'd2,
        OP_CLEAR_ALL  = 2'd3
    } cache_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_UPDATE,
        ST_FLUSH,
        ST_RESP
    } lookup_state_e;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// rtl/plru_tree.sv - tree pseudo-LRU victim select and touch update (combinational)
// Ports:
//   tree      - current tree bits of one set (bit 0 = root, children 2n+1 / 2n+2)
//   touch_way - way being accessed
//   victim    - way the tree currently points at (0 at a node = lower half)
//   tree_next - tree after touching touch_way (path points away from it)
module plru_tree
    import cache_pkg::*;
#(
    parameter int  WAY_BITS = cache_pkg::WAY_BITS,
    localparam int WAYS     = 2 ** WAY_BITS
) (
    input  logic [WAYS-2:0]     tree,
    input  logic [WAY_BITS-1:0] touch_way,
    output logic [WAY_BITS-1:0] victim,
    output logic [WAYS-2:0]     tree_next
);

    logic [WAY_BITS-1:0] node_v;
    logic [WAY_BITS-1:0] node_t;

    // Walk root to leaf; each visited bit supplies the next victim bit, MSB first.
    always_comb begin
        victim = '0;
        node_v = '0;
        for (int l = 0; l < WAY_BITS; l++) begin
            victim[WAY_BITS-1-l] = tree[node_v];
            node_v = WAY_BITS'(2 * int'(node_v) + 1 + int'(tree[node_v]));
        end
    end

    // Follow the accessed way's path and flip each node to the opposite half.
    always_comb begin
        tree_next = tree;
        node_t    = '0;
        for (int l = 0; l < WAY_BITS; l++) begin
            tree_next[node_t] = ~touch_way[WAY_BITS-1-l];
            node_t = WAY_BITS'(2 * int'(node_t) + 1 + int'(touch_way[WAY_BITS-1-l]));
        end
    end

endmodule

// File: rtl/cache_tag_lookup.sv
// rtl/cache_tag_lookup.sv - set-associative tag store with tree PLRU and hit/miss stats
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   req_valid/req_ready            - request handshake (ready only in IDLE)
//   req_op, req_tag, req_index     - operation and address fields from the parser
//   rsp_valid/rsp_ready            - response handshake, outputs held until accepted
//   rsp_hit, rsp_way               - match result and hit/allocated way
//   rsp_evict, rsp_evict_tag       - valid line displaced by allocation
//   hit_count, miss_count          - saturating READ/WRITE statistics
module cache_tag_lookup
    import cache_pkg::*;
#(
    parameter int  ADDR_W    = cache_pkg::ADDR_W,
    parameter int  LINE_BITS = cache_pkg::LINE_BITS,
    parameter int  CAP_BITS  = cache_pkg::CAP_BITS,
    parameter int  WAY_BITS  = cache_pkg::WAY_BITS,
    localparam int INDEX_W   = CAP_BITS - WAY_BITS - LINE_BITS,
    localparam int TAG_W     = ADDR_W - INDEX_W - LINE_BITS,
    localparam int WAYS      = 2 ** WAY_BITS,
    localparam int SETS      = 2 ** INDEX_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [TAG_W-1:0]    req_tag,
    input  logic [INDEX_W-1:0]  req_index,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_hit,
    output logic [WAY_BITS-1:0] rsp_way,
    output logic                rsp_evict,
    output logic [TAG_W-1:0]    rsp_evict_tag,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);

    lookup_state_e state;

    cache_op_e           cap_op;
    logic [TAG_W-1:0]    cap_tag;
    logic [INDEX_W-1:0]  cap_index;
    logic [INDEX_W-1:0]  flush_idx;

    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAYS-2:0]     plru_q  [SETS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];

    // Results latched at the end of COMPARE, consumed in UPDATE.
    logic                cmp_hit;
    logic [WAY_BITS-1:0] cmp_way;
    logic                cmp_victim_valid;
    logic [TAG_W-1:0]    cmp_victim_tag;

    logic [WAYS-1:0]     set_valid;
    logic [WAYS-2:0]     set_plru;
    logic                match_any;
    logic [WAY_BITS-1:0] match_way;
    logic                free_any;
    logic [WAY_BITS-1:0] free_way;
    logic [WAY_BITS-1:0] plru_victim;
    logic [WAYS-2:0]     plru_touched;
    logic [WAY_BITS-1:0] alloc_way;

    assign set_valid = valid_q[cap_index];
    assign set_plru  = plru_q[cap_index];

    // Scan from the top way down so the lowest-numbered match / free way wins.
    always_comb begin
        match_any = 1'b0;
        match_way = '0;
        free_any  = 1'b0;
        free_way  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (set_valid[w] && (tag_q[cap_index][w] == cap_tag)) begin
                match_any = 1'b1;
                match_way = WAY_BITS'(w);
            end
            if (!set_valid[w]) begin
                free_any = 1'b1;
                free_way = WAY_BITS'(w);
            end
        end
    end

    // During COMPARE only the victim is used; during UPDATE the tree is still
    // the captured set's (nothing writes it in between), so the touch of
    // cmp_way is computed against the right bits.
    plru_tree #(
        .WAY_BITS (WAY_BITS)
    ) u_plru (
        .tree      (set_plru),
        .touch_way (cmp_way),
        .victim    (plru_victim),
        .tree_next (plru_touched)
    );

    assign alloc_way = free_any ? free_way : plru_victim;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            req_ready        <= 1'b1;
            rsp_valid        <= 1'b0;
            rsp_hit          <= 1'b0;
            rsp_way          <= '0;
            rsp_evict        <= 1'b0;
            rsp_evict_tag    <= '0;
            hit_count        <= '0;
            miss_count       <= '0;
            cap_op           <= OP_READ;
            cap_tag          <= '0;
            cap_index        <= '0;
            flush_idx        <= '0;
            cmp_hit          <= 1'b0;
            cmp_way          <= '0;
            cmp_victim_valid <= 1'b0;
            cmp_victim_tag   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_op    <= cache_op_e'(req_op);
                        cap_tag   <= req_tag;
                        cap_index <= req_index;
                        flush_idx <= '0;
                        req_ready <= 1'b0;
                        state     <= (cache_op_e'(req_op) == OP_CLEAR_ALL) ? ST_FLUSH : ST_COMPARE;
                    end
                end

                ST_COMPARE: begin
                    cmp_hit          <= match_any;
                    cmp_way          <= match_any ? match_way : alloc_way;
                    cmp_victim_valid <= !match_any && !free_any;
                    cmp_victim_tag   <= tag_q[cap_index][plru_victim];
                    state            <= ST_UPDATE;
                end

                ST_UPDATE: begin
                    rsp_hit       <= cmp_hit;
                    rsp_way       <= cmp_way;
                    rsp_evict     <= 1'b0;
                    rsp_evict_tag <= '0;
                    if (cap_op == OP_INVALIDATE) begin
                        if (cmp_hit) begin
                            valid_q[cap_index][cmp_way] <= 1'b0;
                        end else begin
                            rsp_way <= '0;
                        end
                    end else begin
                        plru_q[cap_index] <= plru_touched;
                        if (cmp_hit) begin
                            hit_count <= sat_inc(hit_count);
                        end else begin
                            valid_q[cap_index][cmp_way] <= 1'b1;
                            rsp_evict     <= cmp_victim_valid;
                            rsp_evict_tag <= cmp_victim_valid ? cmp_victim_tag : '0;
                            miss_count    <= sat_inc(miss_count);
                        end
                    end
                    state <= ST_RESP;
                end

                ST_FLUSH: begin
                    valid_q[flush_idx] <= '0;
                    plru_q[flush_idx]  <= '0;
                    flush_idx          <= flush_idx + INDEX_W'(1);
                    if (flush_idx == '1) begin
                        rsp_hit       <= 1'b0;
                        rsp_way       <= '0;
                        rsp_evict     <= 1'b0;
                        rsp_evict_tag <= '0;
                        state         <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    // rsp_valid is registered from the state, so it rises one
                    // edge after RESP is entered; fields are already stable.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Tag storage needs no reset: a tag is only read where its valid bit is set.
    always_ff @(posedge clk) begin
        if (state == ST_UPDATE && cap_op != OP_INVALIDATE && !cmp_hit) begin
            tag_q[cap_index][cmp_way] <= cap_tag;
        end
    end

endmodule

// File: tb/tb_cache_tag_lookup.sv
// tb/tb_cache_tag_lookup.sv - scoreboard bench for cache_tag_lookup
module tb_cache_tag_lookup;
    import cache_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_op;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_hit;
    logic [WAY_BITS-1:0] rsp_way;
    logic                rsp_evict;
    logic [TAG_W-1:0]    rsp_evict_tag;
    logic [31:0]         hit_count;
    logic [31:0]         miss_count;

    always #5 clk = ~clk;

    cache_tag_lookup dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_tag       (req_tag),
        .req_index     (req_index),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_hit       (rsp_hit),
        .rsp_way       (rsp_way),
        .rsp_evict     (rsp_evict),
        .rsp_evict_tag (rsp_evict_tag),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    int chk_count = 0;
    int err_count = 0;
    int rsp_seen  = 0;

    typedef struct {
        logic                hit;
        logic [WAY_BITS-1:0] way;
        logic                evict;
        logic [TAG_W-1:0]    etag;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Response monitor: compares each transferred response against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst_n && rsp_valid && rsp_ready) begin
            rsp_seen++;
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                check("rsp_hit",       64'(rsp_hit),       64'(e.hit));
                check("rsp_way",       64'(rsp_way),       64'(e.way));
                check("rsp_evict",     64'(rsp_evict),     64'(e.evict));
                check("rsp_evict_tag", 64'(rsp_evict_tag), 64'(e.etag));
            end
        end
    end

    task automatic do_req(input logic [1:0] op, input int tag, input int idx,
                          input logic e_hit, input int e_way, input logic e_evict,
                          input int e_etag, input int e_lat, input int stall);
        exp_t e;
        int   lat;
        int   n;
        logic ok;
        logic                s_hit;
        logic [WAY_BITS-1:0] s_way;
        logic                s_evict;
        logic [TAG_W-1:0]    s_etag;
        e.hit   = e_hit;
        e.way   = WAY_BITS'(e_way);
        e.evict = e_evict;
        e.etag  = TAG_W'(e_etag);
        sb.push_back(e);

        @(negedge clk);
        rsp_ready = (stall == 0);
        req_op    = op;
        req_tag   = TAG_W'(tag);
        req_index = INDEX_W'(idx);
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1 req_valid = 1'b0;

        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(e_lat));

        if (stall > 0) begin
            s_hit   = rsp_hit;
            s_way   = rsp_way;
            s_evict = rsp_evict;
            s_etag  = rsp_evict_tag;
            ok      = 1'b1;
            repeat (stall) begin
                @(posedge clk);
                #1;
                if (rsp_valid !== 1'b1 || rsp_hit !== s_hit || rsp_way !== s_way ||
                    rsp_evict !== s_evict || rsp_evict_tag !== s_etag || req_ready !== 1'b0)
                    ok = 1'b0;
            end
            check("stall_stable", 64'(ok), 64'(1));
            rsp_ready = 1'b1;
        end

        n = 0;
        while (rsp_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rsp_done", 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        int seen0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_tag   = '0;
        req_index = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  64'(req_ready),  64'(1));
        check("rst_rsp_valid",  64'(rsp_valid),  64'(0));
        check("rst_hit_count",  64'(hit_count),  64'(0));
        check("rst_miss_count", 64'(miss_count), 64'(0));
        check("rst_rsp_way",    64'(rsp_way),    64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Cold miss then hit on the same line.
        do_req(OP_READ, 'h1A, 3, 1'b0, 0, 1'b0, 0, 3, 0);
        check("cold_miss_count", 64'(miss_count), 64'(1));
        do_req(OP_READ, 'h1A, 3, 1'b1, 0, 1'b0, 0, 3, 0);
        check("rehit_count", 64'(hit_count), 64'(1));

        // Fill set 5, then force a PLRU eviction.
        for (int i = 0; i < 8; i++)
            do_req(OP_READ, 'h10 + i, 5, 1'b0, i, 1'b0, 0, 3, 0);
        check("fill_miss_count", 64'(miss_count), 64'(9));
        do_req(OP_READ, 'h18, 5, 1'b0, 0, 1'b1, 'h10, 3, 0);
        check("evict_miss_count", 64'(miss_count), 64'(10));

        // Invalidate leaves counters alone; refill uses the freed way.
        do_req(OP_INVALIDATE, 'h11, 5, 1'b1, 1, 1'b0, 0, 3, 0);
        check("inv_hit_count",  64'(hit_count),  64'(1));
        check("inv_miss_count", 64'(miss_count), 64'(10));
        do_req(OP_READ, 'h11, 5, 1'b0, 1, 1'b0, 0, 3, 0);
        check("refill_miss_count", 64'(miss_count), 64'(11));

        // Hit under backpressure, then a WRITE miss evicting the PLRU way 4.
        do_req(OP_READ, 'h18, 5, 1'b1, 0, 1'b0, 0, 3, 10);
        check("bp_hit_count", 64'(hit_count), 64'(2));
        do_req(OP_WRITE, 'h20, 5, 1'b0, 4, 1'b1, 'h14, 3, 0);
        check("write_miss_count", 64'(miss_count), 64'(12));

        // Invalidate miss reports way 0 and changes nothing.
        do_req(OP_INVALIDATE, 'h99, 7, 1'b0, 0, 1'b0, 0, 3, 0);
        check("inv_miss_counters", 64'({hit_count, miss_count}), {32'd2, 32'd12});

        // CLEAR_ALL: 32 flush cycles + 1, then everything misses.
        do_req(OP_CLEAR_ALL, 0, 0, 1'b0, 0, 1'b0, 0, 33, 0);
        do_req(OP_READ, 'h18, 5, 1'b0, 0, 1'b0, 0, 3, 0);
        do_req(OP_READ, 'h1A, 3, 1'b0, 0, 1'b0, 0, 3, 0);
        check("post_clear_counts", 64'({hit_count, miss_count}), {32'd2, 32'd14});

        // Reset in the middle of a flush: no response, full reset state.
        @(negedge clk);
        req_op    = OP_CLEAR_ALL;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(posedge clk);
        seen0 = rsp_seen;
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready",  64'(req_ready),  64'(1));
        check("mid_rst_rsp_valid",  64'(rsp_valid),  64'(0));
        check("mid_rst_counts",     64'({hit_count, miss_count}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("no_partial_rsp", 64'(rsp_seen), 64'(seen0));
        do_req(OP_READ, 'h18, 5, 1'b0, 0, 1'b0, 0, 3, 0);
        check("post_rst_miss_count", 64'(miss_count), 64'(1));

        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", chk_count, err_count);
        $finish;
    end

endmodule
